// File: rtl/mem_axi_hp_bridge.sv
// mem_axi_hp_bridge
// Bridges the Rocket tile's tagged memory interface onto one Zynq HP AXI slave
// port, entirely in the host_clk domain.
//   - Wide memory beats (MEM_DATA_W) are split into RATIO narrower AXI beats on
//     writes; RATIO AXI read beats are reassembled into one memory beat.
//   - Each line is one INCR burst of BURST = LINE_BEATS*RATIO AXI beats.
//   - Write responses are counted (wr_outstanding) and new writes are held off
//     once MAX_WR_OUT bursts are awaiting B.
//   - axi_err is a sticky flag for any non-OKAY bresp/rresp.
// Ports:
//   host_clk, reset          clock, synchronous active-high reset
//   mem_req_cmd_*            command (line address, tag, rw) handshake
//   mem_req_data_*           write beat handshake
//   mem_resp_*               read response (data + tag) handshake
//   axi_ar*/aw*/w*/b*/r*     AXI master channels towards S_AXI_HP0
//   wr_outstanding           number of AW handshakes still awaiting B
//   axi_err                  sticky error flag, cleared only by reset
module mem_axi_hp_bridge #(
    parameter int          MEM_DATA_W = 128,
    parameter int          AXI_DATA_W = 64,
    parameter int          LINE_BEATS = 4,
    parameter int          ADDR_W     = 26,
    parameter int          TAG_W      = 5,
    parameter int          AXI_ID_W   = 6,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          MAX_WR_OUT = 4
) (
    input  logic                            host_clk,
    input  logic                            reset,

    input  logic                            mem_req_cmd_valid,
    output logic                            mem_req_cmd_ready,
    input  logic [ADDR_W-1:0]               mem_req_cmd_addr,
    input  logic [TAG_W-1:0]                mem_req_cmd_tag,
    input  logic                            mem_req_cmd_rw,

    input  logic                            mem_req_data_valid,
    output logic                            mem_req_data_ready,
    input  logic [MEM_DATA_W-1:0]           mem_req_data_bits,

    output logic                            mem_resp_valid,
    input  logic                            mem_resp_ready,
    output logic [MEM_DATA_W-1:0]           mem_resp_data,
    output logic [TAG_W-1:0]                mem_resp_tag,

    output logic                            axi_arvalid,
    input  logic                            axi_arready,
    output logic [31:0]                     axi_araddr,
    output logic [AXI_ID_W-1:0]             axi_arid,
    output logic [7:0]                      axi_arlen,
    output logic [2:0]                      axi_arsize,
    output logic [1:0]                      axi_arburst,

    output logic                            axi_awvalid,
    input  logic                            axi_awready,
    output logic [31:0]                     axi_awaddr,
    output logic [AXI_ID_W-1:0]             axi_awid,
    output logic [7:0]                      axi_awlen,
    output logic [2:0]                      axi_awsize,
    output logic [1:0]                      axi_awburst,

    output logic                            axi_wvalid,
    input  logic                            axi_wready,
    output logic [AXI_DATA_W-1:0]           axi_wdata,
    output logic [AXI_DATA_W/8-1:0]         axi_wstrb,
    output logic                            axi_wlast,

    input  logic                            axi_bvalid,
    output logic                            axi_bready,
    input  logic [AXI_ID_W-1:0]             axi_bid,
    input  logic [1:0]                      axi_bresp,

    input  logic                            axi_rvalid,
    output logic                            axi_rready,
    input  logic [AXI_DATA_W-1:0]           axi_rdata,
    input  logic [AXI_ID_W-1:0]             axi_rid,
    input  logic [1:0]                      axi_rresp,
    input  logic                            axi_rlast,

    output logic [$clog2(MAX_WR_OUT+1)-1:0] wr_outstanding,
    output logic                            axi_err
);

    localparam int RATIO      = MEM_DATA_W / AXI_DATA_W;
    localparam int BURST      = LINE_BEATS * RATIO;
    localparam int BEAT_W     = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int RS_W       = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int OUT_W      = $clog2(MAX_WR_OUT + 1);
    localparam int LINE_SHIFT = $clog2(LINE_BEATS * MEM_DATA_W / 8);

    localparam logic [7:0] AXLEN   = 8'(BURST - 1);
    localparam logic [2:0] AXSIZE  = 3'($clog2(AXI_DATA_W / 8));
    localparam logic [1:0] AXBURST = 2'b01;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_ADDR = 2'd1;
    localparam logic [1:0] S_WR_ADDR = 2'd2;
    localparam logic [1:0] S_WR_DATA = 2'd3;

    logic [1:0]            r_state;
    logic [BEAT_W-1:0]     r_beat;
    logic [31:0]           r_axaddr;
    logic [AXI_ID_W-1:0]   r_arid;
    logic [OUT_W-1:0]      r_wr_out;
    logic [RS_W-1:0]       r_rslice;
    logic                  r_resp_valid;
    logic [MEM_DATA_W-1:0] r_resp_data;
    logic [TAG_W-1:0]      r_resp_tag;
    logic                  r_err;

    logic                  w_wr_start;
    logic                  w_aw_hs;
    logic                  w_b_hs;
    logic                  w_wvalid;
    logic                  w_w_hs;
    logic                  w_wlast;
    logic [RS_W-1:0]       w_wslice;
    logic                  w_rready;
    logic                  w_r_hs;
    logic                  w_r_final;
    logic [MEM_DATA_W-1:0] w_assembled;
    logic                  w_unused;

    // A write is only launched when its first data beat is already present
    // and the B-response tracker has room for one more burst.
    assign w_wr_start = mem_req_cmd_valid && mem_req_cmd_rw && mem_req_data_valid
                        && (r_wr_out < OUT_W'(MAX_WR_OUT));

    assign w_aw_hs  = (r_state == S_WR_ADDR) && axi_awready;
    assign w_b_hs   = axi_bvalid;
    assign w_wvalid = (r_state == S_WR_DATA) && mem_req_data_valid;
    assign w_w_hs   = w_wvalid && axi_wready;
    assign w_wlast  = (r_state == S_WR_DATA) && (r_beat == BEAT_W'(BURST - 1));

    // Low bits of the burst beat counter select which slice of the wide beat
    // is on the W channel; slice 0 is the least significant.
    assign w_wslice = RS_W'(r_beat & BEAT_W'(RATIO - 1));

    // ------------------------------------------------------------------
    // Command FSM and write beat counter
    // ------------------------------------------------------------------
    always_ff @(posedge host_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_req_cmd_valid && !mem_req_cmd_rw) begin
                        r_state <= S_RD_ADDR;
                    end else if (w_wr_start) begin
                        r_state <= S_WR_ADDR;
                    end
                end
                S_RD_ADDR: begin
                    if (axi_arready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_WR_ADDR: begin
                    if (axi_awready) begin
                        r_state <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (w_w_hs) begin
                        if (w_wlast) begin
                            r_beat  <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_beat <= r_beat + BEAT_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Address and ID are captured while idle so they stay stable for the whole
    // time the address channel is waiting for ready.
    always_ff @(posedge host_clk) begin
        if ((r_state == S_IDLE) && mem_req_cmd_valid) begin
            r_axaddr <= BASE_ADDR | (32'(mem_req_cmd_addr) << LINE_SHIFT);
            r_arid   <= AXI_ID_W'(mem_req_cmd_tag);
        end
    end

    // ------------------------------------------------------------------
    // Outstanding write response counter
    // ------------------------------------------------------------------
    always_ff @(posedge host_clk) begin
        if (reset) begin
            r_wr_out <= '0;
        end else if (w_aw_hs && !w_b_hs) begin
            r_wr_out <= r_wr_out + OUT_W'(1);
        end else if (!w_aw_hs && w_b_hs && (r_wr_out != '0)) begin
            r_wr_out <= r_wr_out - OUT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Read reassembly and response register
    // ------------------------------------------------------------------
    assign w_rready  = !r_resp_valid || mem_resp_ready;
    assign w_r_hs    = axi_rvalid && w_rready;
    assign w_r_final = (r_rslice == RS_W'(RATIO - 1));

    generate
        if (RATIO == 1) begin : g_no_stage
            assign w_assembled = axi_rdata;
        end else begin : g_stage
            logic [MEM_DATA_W-AXI_DATA_W-1:0] r_stage;

            // Slices 0..RATIO-2 wait here; the final slice bypasses straight
            // into the response register so there is no extra cycle.
            always_ff @(posedge host_clk) begin
                if (w_r_hs && !w_r_final) begin
                    r_stage[int'(r_rslice)*AXI_DATA_W +: AXI_DATA_W] <= axi_rdata;
                end
            end

            assign w_assembled = {axi_rdata, r_stage};
        end
    endgenerate

    always_ff @(posedge host_clk) begin
        if (reset) begin
            r_rslice     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_tag   <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_r_hs) begin
                r_rslice <= w_r_final ? '0 : r_rslice + RS_W'(1);
            end
            // A reload in the same cycle as the consumer's handshake keeps
            // valid high, which is what gives bubble-free streaming.
            if (w_r_hs && w_r_final) begin
                r_resp_valid <= 1'b1;
                r_resp_data  <= w_assembled;
                r_resp_tag   <= axi_rid[TAG_W-1:0];
            end else if (mem_resp_ready) begin
                r_resp_valid <= 1'b0;
            end
            if ((axi_bvalid && (axi_bresp != 2'b00)) || (w_r_hs && (axi_rresp != 2'b00))) begin
                r_err <= 1'b1;
            end
        end
    end

    // rlast and the B/R IDs carry no information this bridge needs: bursts are
    // fixed length and only one write ID is ever used.
    assign w_unused = ^{axi_rlast, axi_bid, axi_rid};

    assign mem_req_cmd_ready  = ((r_state == S_RD_ADDR) && axi_arready) || w_aw_hs;
    assign mem_req_data_ready = w_w_hs && (w_wslice == RS_W'(RATIO - 1));

    assign mem_resp_valid = r_resp_valid;
    assign mem_resp_data  = r_resp_data;
    assign mem_resp_tag   = r_resp_tag;

    assign axi_arvalid = (r_state == S_RD_ADDR);
    assign axi_araddr  = r_axaddr;
    assign axi_arid    = r_arid;
    assign axi_arlen   = AXLEN;
    assign axi_arsize  = AXSIZE;
    assign axi_arburst = AXBURST;

    assign axi_awvalid = (r_state == S_WR_ADDR);
    assign axi_awaddr  = r_axaddr;
    assign axi_awid    = '0;
    assign axi_awlen   = AXLEN;
    assign axi_awsize  = AXSIZE;
    assign axi_awburst = AXBURST;

    assign axi_wvalid = w_wvalid;
    assign axi_wdata  = AXI_DATA_W'(mem_req_data_bits >> (int'(w_wslice) * AXI_DATA_W));
    assign axi_wstrb  = '1;
    assign axi_wlast  = w_wlast;

    assign axi_bready = 1'b1;
    assign axi_rready = w_rready;

    assign wr_outstanding = r_wr_out;
    assign axi_err        = r_err;

endmodule

// File: tb/tb_mem_axi_hp_bridge.sv
// Self-checking bench for mem_axi_hp_bridge with default parameters
// (128-bit memory beats, 64-bit AXI, 4-beat lines, 8-beat bursts).
module tb_mem_axi_hp_bridge;

    logic         host_clk;
    logic         reset;
    logic         mem_req_cmd_valid, mem_req_cmd_ready, mem_req_cmd_rw;
    logic [25:0]  mem_req_cmd_addr;
    logic [4:0]   mem_req_cmd_tag;
    logic         mem_req_data_valid, mem_req_data_ready;
    logic [127:0] mem_req_data_bits;
    logic         mem_resp_valid, mem_resp_ready;
    logic [127:0] mem_resp_data;
    logic [4:0]   mem_resp_tag;
    logic         axi_arvalid, axi_arready;
    logic [31:0]  axi_araddr;
    logic [5:0]   axi_arid;
    logic [7:0]   axi_arlen;
    logic [2:0]   axi_arsize;
    logic [1:0]   axi_arburst;
    logic         axi_awvalid, axi_awready;
    logic [31:0]  axi_awaddr;
    logic [5:0]   axi_awid;
    logic [7:0]   axi_awlen;
    logic [2:0]   axi_awsize;
    logic [1:0]   axi_awburst;
    logic         axi_wvalid, axi_wready, axi_wlast;
    logic [63:0]  axi_wdata;
    logic [7:0]   axi_wstrb;
    logic         axi_bvalid, axi_bready;
    logic [5:0]   axi_bid;
    logic [1:0]   axi_bresp;
    logic         axi_rvalid, axi_rready, axi_rlast;
    logic [63:0]  axi_rdata;
    logic [5:0]   axi_rid;
    logic [1:0]   axi_rresp;
    logic [2:0]   wr_outstanding;
    logic         axi_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0]  rdata;
        logic         exp_vld;
        logic [127:0] exp_data;
    } rd_vec_t;

    rd_vec_t      rv[8];
    logic [63:0]  rd_data[8];
    logic [127:0] wbeats[4];

    mem_axi_hp_bridge dut (
        .host_clk(host_clk), .reset(reset),
        .mem_req_cmd_valid(mem_req_cmd_valid), .mem_req_cmd_ready(mem_req_cmd_ready),
        .mem_req_cmd_addr(mem_req_cmd_addr), .mem_req_cmd_tag(mem_req_cmd_tag),
        .mem_req_cmd_rw(mem_req_cmd_rw),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
        .axi_arid(axi_arid), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awid(axi_awid), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bid(axi_bid),
        .axi_bresp(axi_bresp),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
        .axi_rid(axi_rid), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .wr_outstanding(wr_outstanding), .axi_err(axi_err)
    );

    initial host_clk = 1'b0;
    always #5 host_clk = ~host_clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Every step starts 1 time unit after a rising edge.
    task automatic tick();
        @(posedge host_clk);
        #1;
    endtask

    task automatic start_read(input logic [25:0] addr, input logic [4:0] tag);
        mem_req_cmd_valid = 1'b1;
        mem_req_cmd_rw    = 1'b0;
        mem_req_cmd_addr  = addr;
        mem_req_cmd_tag   = tag;
    endtask

    task automatic ar_hs(input logic [31:0] exp_addr, input logic [5:0] exp_id);
        check("arvalid", axi_arvalid, 1);
        check("araddr", axi_araddr, exp_addr);
        check("arid", axi_arid, exp_id);
        check("arlen", axi_arlen, 7);
        check("arsize", axi_arsize, 3);
        check("arburst", axi_arburst, 1);
        axi_arready = 1'b1;
        #1;
        check("cmd_ready_ar", mem_req_cmd_ready, 1);
        tick();
        axi_arready       = 1'b0;
        mem_req_cmd_valid = 1'b0;
        #1;
        check("ar_dropped", axi_arvalid, 0);
    endtask

    // Streams rd_data[0..7] and collects the four reassembled responses.
    // mem_resp_ready is held low for the first 'hold' cycles.
    task automatic run_read(input int hold, input logic [4:0] tag);
        int k     = 0;
        int nresp = 0;
        int used  = 0;
        for (int cyc = 0; cyc < 60 && nresp < 4; cyc++) begin
            used++;
            mem_resp_ready = (cyc >= hold);
            if (k < 8) begin
                axi_rvalid = 1'b1;
                axi_rdata  = rd_data[k];
                axi_rid    = 6'(tag);
                axi_rresp  = 2'b00;
                axi_rlast  = (k == 7);
            end else begin
                axi_rvalid = 1'b0;
                axi_rlast  = 1'b0;
            end
            #1;
            if (hold > 4 && cyc == hold - 1) begin
                check("bp_rready_low", axi_rready, 0);
                check("bp_resp_held_valid", mem_resp_valid, 1);
                check("bp_resp_held_data", mem_resp_data, {rd_data[1], rd_data[0]});
            end
            if (mem_resp_valid && mem_resp_ready) begin
                check($sformatf("resp_data%0d", nresp), mem_resp_data,
                      {rd_data[2*nresp+1], rd_data[2*nresp]});
                check($sformatf("resp_tag%0d", nresp), mem_resp_tag, tag);
                nresp++;
            end
            if (axi_rvalid && axi_rready) k++;
            tick();
        end
        axi_rvalid     = 1'b0;
        axi_rlast      = 1'b0;
        mem_resp_ready = 1'b1;
        check("read_resp_count", nresp, 4);
        check("read_beats_taken", k, 8);
        if (hold == 0) check("read_no_bubbles_cycles", used, 9);
    endtask

    task automatic start_write(input logic [25:0] addr);
        mem_req_cmd_valid  = 1'b1;
        mem_req_cmd_rw     = 1'b1;
        mem_req_cmd_addr   = addr;
        mem_req_cmd_tag    = 5'd7;
        mem_req_data_valid = 1'b1;
        mem_req_data_bits  = wbeats[0];
    endtask

    task automatic aw_hs(input logic [31:0] exp_addr, input logic with_b, input logic [1:0] bresp);
        check("awvalid", axi_awvalid, 1);
        check("awaddr", axi_awaddr, exp_addr);
        check("awid", axi_awid, 0);
        check("awlen", axi_awlen, 7);
        check("awsize", axi_awsize, 3);
        check("wvalid_before_aw", axi_wvalid, 0);
        axi_awready = 1'b1;
        axi_bvalid  = with_b;
        axi_bresp   = bresp;
        #1;
        check("cmd_ready_aw", mem_req_cmd_ready, 1);
        tick();
        axi_awready       = 1'b0;
        axi_bvalid        = 1'b0;
        axi_bresp         = 2'b00;
        mem_req_cmd_valid = 1'b0;
    endtask

    task automatic w_beats(input int n);
        axi_wready = 1'b1;
        for (int j = 0; j < n; j++) begin
            mem_req_data_bits = wbeats[j/2];
            #1;
            check($sformatf("wvalid%0d", j), axi_wvalid, 1);
            check($sformatf("wdata%0d", j), axi_wdata, wbeats[j/2][(j%2)*64 +: 64]);
            check($sformatf("wlast%0d", j), axi_wlast, (j == 7));
            check($sformatf("data_ready%0d", j), mem_req_data_ready, (j % 2 == 1));
            check("wstrb", axi_wstrb, 8'hFF);
            tick();
        end
        axi_wready = 1'b0;
    endtask

    task automatic do_write(input logic [25:0] addr, input logic [31:0] exp_addr);
        start_write(addr);
        tick();
        aw_hs(exp_addr, 1'b0, 2'b00);
        w_beats(8);
        check("w_done_idle", axi_wvalid, 0);
        mem_req_data_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) rd_data[i] = 64'hDA7A_0000_0000_0000 | 64'(i);
        for (int i = 0; i < 4; i++)
            wbeats[i] = {64'hF00D_0000_0000_0000 | 64'(2*i+1), 64'hF00D_0000_0000_0000 | 64'(2*i)};
        rv[0] = '{64'hDA7A_0000_0000_0000, 1'b0, 128'h0};
        rv[1] = '{64'hDA7A_0000_0000_0001, 1'b1, 128'hDA7A_0000_0000_0001_DA7A_0000_0000_0000};
        rv[2] = '{64'hDA7A_0000_0000_0002, 1'b0, 128'h0};
        rv[3] = '{64'hDA7A_0000_0000_0003, 1'b1, 128'hDA7A_0000_0000_0003_DA7A_0000_0000_0002};
        rv[4] = '{64'hDA7A_0000_0000_0004, 1'b0, 128'h0};
        rv[5] = '{64'hDA7A_0000_0000_0005, 1'b1, 128'hDA7A_0000_0000_0005_DA7A_0000_0000_0004};
        rv[6] = '{64'hDA7A_0000_0000_0006, 1'b0, 128'h0};
        rv[7] = '{64'hDA7A_0000_0000_0007, 1'b1, 128'hDA7A_0000_0000_0007_DA7A_0000_0000_0006};

        reset = 1'b1;
        mem_req_cmd_valid = 1'b0; mem_req_cmd_rw = 1'b0; mem_req_cmd_addr = '0; mem_req_cmd_tag = '0;
        mem_req_data_valid = 1'b0; mem_req_data_bits = '0; mem_resp_ready = 1'b1;
        axi_arready = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0;
        axi_bvalid = 1'b0; axi_bid = '0; axi_bresp = 2'b00;
        axi_rvalid = 1'b0; axi_rdata = '0; axi_rid = '0; axi_rresp = 2'b00; axi_rlast = 1'b0;

        // Reset state
        tick(); tick(); tick();
        check("rst_arvalid", axi_arvalid, 0);
        check("rst_awvalid", axi_awvalid, 0);
        check("rst_wvalid", axi_wvalid, 0);
        check("rst_resp_valid", mem_resp_valid, 0);
        check("rst_cmd_ready", mem_req_cmd_ready, 0);
        check("rst_data_ready", mem_req_data_ready, 0);
        check("rst_wlast", axi_wlast, 0);
        check("rst_resp_data", mem_resp_data, 0);
        check("rst_wr_out", wr_outstanding, 0);
        check("rst_axi_err", axi_err, 0);
        check("rst_rready", axi_rready, 1);
        check("rst_bready", axi_bready, 1);
        reset = 1'b0;
        tick();

        // Read with defaults, table-driven R beats
        start_read(26'h123, 5'd5);
        tick();
        check("ar_latency_valid", axi_arvalid, 1);
        check("cmd_ready_wait", mem_req_cmd_ready, 0);
        tick();
        ar_hs(32'h1000_48C0, 6'd5);
        mem_resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            axi_rvalid = 1'b1;
            axi_rdata  = rv[i].rdata;
            axi_rid    = 6'd5;
            axi_rresp  = 2'b00;
            axi_rlast  = (i == 7);
            #1;
            check($sformatf("rd_rready%0d", i), axi_rready, 1);
            tick();
            check($sformatf("rd_vld%0d", i), mem_resp_valid, rv[i].exp_vld);
            if (rv[i].exp_vld) begin
                check($sformatf("rd_data%0d", i), mem_resp_data, rv[i].exp_data);
                check($sformatf("rd_tag%0d", i), mem_resp_tag, 5);
            end
        end
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        tick();
        check("rd_done_vld", mem_resp_valid, 0);

        // Write with defaults
        do_write(26'h123, 32'h1000_48C0);
        check("wr_out_after_write", wr_outstanding, 1);
        axi_bvalid = 1'b1;
        tick();
        axi_bvalid = 1'b0;
        check("wr_out_after_b", wr_outstanding, 0);
        check("err_after_okay_b", axi_err, 0);

        // Back-pressure on mem_resp
        start_read(26'h010, 5'd3);
        tick();
        ar_hs(32'h1000_0400, 6'd3);
        run_read(10, 5'd3);

        // Outstanding limit
        for (int w = 0; w < 4; w++) do_write(26'h200 + 26'(w), 32'h1000_8000 + 32'(w*64));
        check("wr_out_full", wr_outstanding, 4);
        start_read(26'h040, 5'd2);
        tick();
        ar_hs(32'h1000_1000, 6'd2);
        run_read(0, 5'd2);
        start_write(26'h300);
        tick(); tick(); tick();
        check("full_stall_aw", axi_awvalid, 0);
        check("full_stall_cmd_ready", mem_req_cmd_ready, 0);
        axi_bvalid = 1'b1;
        tick();
        axi_bvalid = 1'b0;
        check("wr_out_after_one_b", wr_outstanding, 3);
        check("aw_not_yet", axi_awvalid, 0);
        tick();
        aw_hs(32'h1000_C000, 1'b1, 2'b00);
        check("aw_b_same_cycle", wr_outstanding, 3);
        w_beats(8);
        mem_req_data_valid = 1'b0;
        check("err_still_clear", axi_err, 0);
        axi_bvalid = 1'b1;
        axi_bresp  = 2'b10;
        tick();
        axi_bvalid = 1'b0;
        axi_bresp  = 2'b00;
        check("err_on_slverr", axi_err, 1);
        check("wr_out_after_err_b", wr_outstanding, 2);
        tick(); tick(); tick();
        check("err_sticky", axi_err, 1);
        axi_bvalid = 1'b1;
        tick(); tick();
        axi_bvalid = 1'b0;
        check("wr_out_drained", wr_outstanding, 0);

        // Reset in the middle of a write burst
        start_write(26'h055);
        tick();
        aw_hs(32'h1000_1540, 1'b0, 2'b00);
        w_beats(4);
        check("mid_wr_out", wr_outstanding, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_awvalid", axi_awvalid, 0);
        check("mr_wvalid", axi_wvalid, 0);
        check("mr_wlast", axi_wlast, 0);
        check("mr_arvalid", axi_arvalid, 0);
        check("mr_resp_valid", mem_resp_valid, 0);
        check("mr_data_ready", mem_req_data_ready, 0);
        check("mr_wr_out", wr_outstanding, 0);
        check("mr_axi_err", axi_err, 0);
        mem_req_data_valid = 1'b0;
        tick();
        start_read(26'h001, 5'd9);
        tick();
        ar_hs(32'h1000_0040, 6'd9);
        run_read(0, 5'd9);
        do_write(26'h002, 32'h1000_0080);
        check("post_rst_wr_out", wr_outstanding, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
